// File: rtl/contador_sincrono_param.sv
// Parametrised synchronous modulo counter: 0..LIMIT, up/down, load, TC flag and WRAP pulse.
// Define SATURATE_EN to saturate at the bounds instead of wrapping.
module contador_sincrono_param #(
    parameter int unsigned           WIDTH     = 3,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D_IN,
    input  logic [WIDTH-1:0] LIMIT,
    output logic [WIDTH-1:0] Q_out,
    output logic             TC,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             at_top, at_zero;

    // at_top also covers a count left above a freshly lowered LIMIT
    assign at_top  = (q_q >= LIMIT);
    assign at_zero = (q_q == '0);

    assign TC    = EN & ((UP & at_top) | (~UP & at_zero));
    assign Q_out = q_q;
    assign WRAP  = wrap_q;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (LOAD) begin
            q_d = (D_IN > LIMIT) ? LIMIT : D_IN;
        end else if (EN) begin
            if (UP) begin
                if (at_top) begin
`ifdef SATURATE_EN
                    q_d = LIMIT;
`else
                    q_d = '0;
`endif
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + One;
                end
            end else begin
                if (at_zero) begin
`ifdef SATURATE_EN
                    q_d = '0;
`else
                    q_d = LIMIT;
`endif
                    wrap_d = 1'b1;
                end else if (q_q > LIMIT) begin
                    q_d = LIMIT;
                end else begin
                    q_d = q_q - One;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            q_q    <= RESET_VAL;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

endmodule
